// File: rtl/sng_bank16.sv
// -----------------------------------------------------------------------------
// sng_bank16 -- sixteen-channel stochastic number generator bank.
//
// Turns sixteen WIDTH-bit unsigned operands into sixteen unipolar bitstreams
// of LEN bits each. The bank drives the 16-bit input bus of the downstream
// non-scaled unary adder. All channels share one maximal-length Fibonacci
// LFSR. Each channel compares its operand against its own rotation of the
// LFSR state. Every rotation is a bijection on the nonzero states, so over a
// full LFSR period a channel emits exactly operand_i ones.
//
// Optional build macro:
//   SNG_CONT_EN -- continuous mode. The stream restarts at every period
//                  boundary, operands are re-latched there, and done pulses
//                  with the first bit of each new period. When undefined,
//                  the bank runs in single-shot mode.
//
// Ports:
//   clk       in   clock, rising edge
//   rst       in   asynchronous reset, active-high
//   start     in   begin a stream (sampled only in IDLE)
//   stop      in   abort the current stream (sampled in RUN)
//   value     in   NCH*WIDTH operands; channel i = value[i*WIDTH +: WIDTH]
//   seed      in   LFSR seed, latched on an accepted start (0 becomes 1)
//   out       out  NCH stream bits, one per channel
//   out_valid out  out carries a valid stream bit
//   busy      out  block is not in IDLE
//   done      out  one-cycle pulse after the last stream bit
// -----------------------------------------------------------------------------
module sng_bank16 #(
    parameter int WIDTH = 8,
    parameter int LEN   = 255,
    parameter int NCH   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 stop,
    input  logic [NCH*WIDTH-1:0] value,
    input  logic [WIDTH-1:0]     seed,
    output logic [NCH-1:0]       out,
    output logic                 out_valid,
    output logic                 busy,
    output logic                 done
);

    generate
        if (!(WIDTH == 4 || WIDTH == 8 || WIDTH == 10)) begin : g_bad_width
            $error("sng_bank16: WIDTH must be 4, 8 or 10");
        end
        if (LEN < 1 || LEN > (2 ** WIDTH) - 1) begin : g_bad_len
            $error("sng_bank16: LEN must be in 1 .. 2**WIDTH-1");
        end
        if (NCH != 16) begin : g_bad_nch
            $error("sng_bank16: NCH is fixed at 16");
        end
    endgenerate

    // Feedback tap masks (bit k set = 1-based tap k+1):
    // 4: x^4+x^3+1, 8: x^8+x^6+x^5+x^4+1, 10: x^10+x^7+1.
    localparam logic [WIDTH-1:0] TAPS = (WIDTH == 4) ? WIDTH'(4'hC) :
                                        (WIDTH == 8) ? WIDTH'(8'hB8) :
                                                       WIDTH'(10'h240);
    localparam logic [WIDTH-1:0] LAST = WIDTH'(LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [NCH*WIDTH-1:0]   op_q, op_d;
    logic [WIDTH-1:0]       lfsr_q, lfsr_d;
    logic [WIDTH-1:0]       cnt_q, cnt_d;
    logic [NCH-1:0]         out_q, out_d;
    logic                   out_valid_q, out_valid_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
`ifdef SNG_CONT_EN
    // Set on the period-wrap edge so done lines up with the next period's first bit.
    logic                   wrap_q, wrap_d;
`endif

    function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] s);
        return {s[WIDTH-2:0], ^(s & TAPS)};
    endfunction

    function automatic logic [WIDTH-1:0] rotl(input logic [WIDTH-1:0] s, input int sh);
        logic [WIDTH-1:0] r;
        r = '0;
        for (int b = 0; b < WIDTH; b++) begin
            r[(b + sh) % WIDTH] = s[b];
        end
        return r;
    endfunction

    // The threshold rotl(s)-1 ranges over 0 .. 2^WIDTH-2 as s walks the
    // nonzero states. Therefore operand > threshold holds for exactly
    // operand states.
    function automatic logic [NCH-1:0] stream_bits(input logic [NCH*WIDTH-1:0] ops,
                                                   input logic [WIDTH-1:0]     s);
        logic [NCH-1:0]   b;
        logic [WIDTH-1:0] thr;
        b = '0;
        for (int i = 0; i < NCH; i++) begin
            thr  = rotl(s, i % WIDTH) - WIDTH'(1);
            b[i] = (ops[i*WIDTH +: WIDTH] > thr);
        end
        return b;
    endfunction

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        lfsr_d      = lfsr_q;
        cnt_d       = cnt_q;
        out_d       = '0;
        out_valid_d = 1'b0;
        done_d      = 1'b0;
`ifdef SNG_CONT_EN
        wrap_d      = 1'b0;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d    = value;
                    lfsr_d  = (seed == '0) ? WIDTH'(1) : seed;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (stop) begin
                    // Abort: the LFSR keeps its state, and no done pulse is emitted.
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    out_d       = stream_bits(op_q, lfsr_q);
                    out_valid_d = 1'b1;
                    lfsr_d      = lfsr_next(lfsr_q);
                    cnt_d       = cnt_q + WIDTH'(1);
`ifdef SNG_CONT_EN
                    done_d = wrap_q;
                    if (cnt_q == LAST) begin
                        cnt_d  = '0;
                        op_d   = value;
                        wrap_d = 1'b1;
                    end
`else
                    if (cnt_q == LAST) begin
                        state_d = S_DONE;
                    end
`endif
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            op_q        <= '0;
            lfsr_q      <= WIDTH'(1);
            cnt_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef SNG_CONT_EN
            wrap_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            lfsr_q      <= lfsr_d;
            cnt_q       <= cnt_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
`ifdef SNG_CONT_EN
            wrap_q      <= wrap_d;
`endif
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_sng_bank16.sv
// -----------------------------------------------------------------------------
// tb_sng_bank16 -- self-checking bench for sng_bank16 (WIDTH=8, LEN=255).
// Holds a reference model of the LFSR and the per-channel comparison. It
// queues the expected {out, out_valid, done, busy} for every cycle and
// checks the outputs once per cycle. It also checks ones-counts against
// hand-computed values.
// -----------------------------------------------------------------------------
module tb_sng_bank16;

    localparam int W = 8;
    localparam int L = 255;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          stop;
    logic [127:0]  value;
    logic [7:0]    seed;
    logic [15:0]   out;
    logic          out_valid;
    logic          busy;
    logic          done;

    sng_bank16 #(.WIDTH(W), .LEN(L), .NCH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .value     (value),
        .seed      (seed),
        .out       (out),
        .out_valid (out_valid),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int ones[16];
    int nvalid;
    int ndone;

    // Expected per-cycle outputs {out[15:0], out_valid, done, busy}; idle when empty.
    logic [18:0] expq[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference model: x^8+x^6+x^5+x^4+1 shifting left; the new LSB is the
    // parity of bits 8,6,5,4 (1-based).
    function automatic logic [7:0] m_next(input logic [7:0] s);
        logic fb;
        fb = s[7] ^ s[5] ^ s[4] ^ s[3];
        return {s[6:0], fb};
    endfunction

    function automatic logic [7:0] m_rotl(input logic [7:0] s, input int k);
        return (s << k) | (s >> (8 - k));
    endfunction

    function automatic logic [15:0] m_bits(input logic [127:0] v, input logic [7:0] s);
        logic [15:0] b;
        logic [7:0]  r;
        for (int i = 0; i < 16; i++) begin
            r    = m_rotl(s, i % 8) - 8'd1;
            b[i] = (v[i*8 +: 8] > r);
        end
        return b;
    endfunction

    function automatic logic [18:0] mk(input logic [15:0] o, input logic v, input logic d,
                                       input logic b);
        return {o, v, d, b};
    endfunction

    // Expected outputs for a stream starting from an accepted start.
    task automatic push_run(input logic [127:0] v, input logic [7:0] sd, input int nbits,
                            input bit with_done);
        logic [7:0] s;
        s = (sd == 8'd0) ? 8'd1 : sd;
        expq.push_back(mk(16'h0, 1'b0, 1'b0, 1'b1));
        for (int k = 1; k <= nbits; k++) begin
            expq.push_back(mk(m_bits(v, s), 1'b1, 1'b0, 1'b1));
            s = m_next(s);
        end
        if (with_done) expq.push_back(mk(16'h0, 1'b0, 1'b1, 1'b0));
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic clear_stats();
        for (int i = 0; i < 16; i++) ones[i] = 0;
        nvalid = 0;
        ndone  = 0;
    endtask

    task automatic check_ones(input string tag, input logic [127:0] v);
        for (int i = 0; i < 16; i++)
            chk($sformatf("%s ones ch%0d", tag, i), 64'(ones[i]), 64'(v[i*8 +: 8]));
    endtask

    // Full single-shot run with start pulsed for one cycle.
    task automatic do_run(input string tag, input logic [127:0] v, input logic [7:0] sd);
        clear_stats();
        value = v;
        seed  = sd;
        start = 1'b1;
        push_run(v, sd, L, 1'b1);
        tick();
        start = 1'b0;
        repeat (L + 2) tick();
        chk({tag, " valid cycles"}, 64'(nvalid), 64'(L));
        chk({tag, " done pulses"}, 64'(ndone), 64'd1);
        check_ones(tag, v);
    endtask

    // Per-cycle compare against the expectation queue.
    initial begin
        logic [18:0] e;
        forever begin
            @(posedge clk);
            #1;
            e = (expq.size() > 0) ? expq.pop_front() : 19'h0;
            chk("cycle outputs {out,valid,done,busy}", 64'({out, out_valid, done, busy}), 64'(e));
            if (out_valid) begin
                nvalid++;
                for (int i = 0; i < 16; i++) ones[i] += int'(out[i]);
            end
            if (done) ndone++;
        end
    end

    initial begin
        logic [127:0] v;
        logic [127:0] v2;
        logic [7:0]   s;
        int           per;
        int           mcount;
        bit           hit0;

        rst   = 1'b1;
        start = 1'b0;
        stop  = 1'b0;
        value = '0;
        seed  = '0;
        clear_stats();
        repeat (3) tick();
        chk("reset outputs", 64'({out, out_valid, busy, done}), 64'd0);
        rst = 1'b0;
        tick();

        // Pin the model with hand-computed values.
        chk("model next 08", 64'(m_next(8'h08)), 64'h11);
        chk("model next 80", 64'(m_next(8'h80)), 64'h01);
        chk("model rotl 81", 64'(m_rotl(8'h81, 1)), 64'h03);
        chk("model bits s=01 v=128", 64'(m_bits({16{8'd128}}, 8'h01)), 64'hFFFF);
        chk("model bits s=FF v=128", 64'(m_bits({16{8'd128}}, 8'hFF)), 64'h0000);
        s = 8'd1; per = 0; hit0 = 1'b0; mcount = 0;
        do begin
            mcount += int'(m_bits({16{8'd128}}, s)[3]);
            s = m_next(s);
            per++;
            if (s == 8'd0) hit0 = 1'b1;
        end while (s != 8'd1 && per < 300);
        chk("model period", 64'(per), 64'd255);
        chk("model never zero", 64'(hit0), 64'd0);
        chk("model ones v=128", 64'(mcount), 64'd128);

`ifndef SNG_CONT_EN
        // 1: all channels 128, seed 1.
        do_run("t1", {16{8'd128}}, 8'd1);
        chk("t1 busy after", 64'(busy), 64'd0);

        // 2: boundary operands 0 and 255.
        v = {{14{8'd37}}, 8'd255, 8'd0};
        do_run("t2", v, 8'd1);
        chk("t2 ch0 ones", 64'(ones[0]), 64'd0);
        chk("t2 ch1 ones", 64'(ones[1]), 64'd255);
        chk("t2 ch2 ones", 64'(ones[2]), 64'd37);

        // 3: seed 0 behaves as seed 1.
        do_run("t3 seed0", {16{8'd200}}, 8'd0);
        do_run("t3 seed1", {16{8'd200}}, 8'd1);

        // 4: stop during the 10th valid cycle.
        clear_stats();
        v = {16{8'd99}};
        value = v;
        seed  = 8'd5;
        start = 1'b1;
        push_run(v, 8'd5, 10, 1'b0);
        tick();
        start = 1'b0;
        repeat (10) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        repeat (3) tick();
        chk("t4 valid cycles", 64'(nvalid), 64'd10);
        chk("t4 no done", 64'(ndone), 64'd0);
        chk("t4 busy", 64'(busy), 64'd0);
        do_run("t4 restart", {16{8'd99}}, 8'd5);

        // 5a: start held through the run; value changes mid-run.
        clear_stats();
        for (int i = 0; i < 16; i++) v[i*8 +: 8] = 8'(16 * i + 3);
        value = v;
        seed  = 8'd77;
        start = 1'b1;
        push_run(v, 8'd77, L, 1'b1);
        repeat (50) tick();
        value = {16{8'd10}};
        repeat (L + 2 - 50) tick();
        start = 1'b0;
        tick();
        chk("t5 valid cycles", 64'(nvalid), 64'(L));
        chk("t5 done pulses", 64'(ndone), 64'd1);
        check_ones("t5", v);

        // 5b: asynchronous reset mid-run.
        clear_stats();
        v = {16{8'd150}};
        value = v;
        seed  = 8'd9;
        start = 1'b1;
        push_run(v, 8'd9, 19, 1'b0);
        tick();
        start = 1'b0;
        repeat (19) tick();
        #2;
        rst = 1'b1;
        expq.delete();
        #1;
        chk("t5 rst outputs", 64'({out, out_valid, busy, done}), 64'd0);
        tick();
        rst = 1'b0;
        repeat (3) tick();
        chk("t5 rst valid cycles", 64'(nvalid), 64'd19);
        chk("t5 rst no done", 64'(ndone), 64'd0);
`else
        // 6: continuous mode, 64 then 192.
        clear_stats();
        v  = {16{8'd64}};
        v2 = {16{8'd192}};
        value = v;
        seed  = 8'd1;
        start = 1'b1;
        s = 8'd1;
        expq.push_back(mk(16'h0, 1'b0, 1'b0, 1'b1));
        for (int k = 1; k <= 511; k++) begin
            expq.push_back(mk(m_bits((k <= 255) ? v : v2, s), 1'b1,
                              (k == 256 || k == 511), 1'b1));
            s = m_next(s);
        end
        tick();
        start = 1'b0;
        repeat (98) tick();
        value = v2;
        repeat (157) tick();
        check_ones("t6 period1", v);
        for (int i = 0; i < 16; i++) ones[i] = 0;
        repeat (255) tick();
        check_ones("t6 period2", v2);
        tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        repeat (3) tick();
        chk("t6 valid cycles", 64'(nvalid), 64'd511);
        chk("t6 done pulses", 64'(ndone), 64'd2);
`endif

        repeat (2) tick();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/sng_bank16.md
Name: sng_bank16

Overview:
- Sixteen-channel stochastic number generator (SNG) bank.
- Converts sixteen WIDTH-bit binary operands into sixteen unipolar bitstreams of length LEN.
- Sits directly upstream of the 16-input non-scaled unary adder and drives its 16-bit input bus.
- All channels share one LFSR; each channel compares its operand against a channel-specific rotation of the LFSR state, so every stream has an exact ones-count per period.

Parameters:
- WIDTH, 8, operand/LFSR precision. Legal values: 4, 8, 10. Any other value is an elaboration error.
- LEN, 255, bitstream length in cycles, 1 to 2^WIDTH-1.
- NCH, 16, channel count. Fixed at 16; do not override.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-high
- start  in  1  begin a stream; sampled only in IDLE
- stop  in  1  abort current stream; sampled in RUN
- value  in  NCH*WIDTH  operands; channel i = value[i*WIDTH +: WIDTH]
- seed  in  WIDTH  LFSR seed, latched on accepted start
- out  out  NCH  stream bits, one per channel; feeds the adder input
- out_valid  out  1  out carries a valid stream bit
- busy  out  1  block not in IDLE
- done  out  1  one-cycle pulse after the last stream bit

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high on rst; all state clears immediately on assertion.
- Reset values: state=IDLE, out=0, out_valid=0, busy=0, done=0, lfsr=1, cnt=0, latched operands=0.
- Registered outputs: all outputs are registered; no combinational path from inputs to outputs.
- States: IDLE, RUN, DONE.
- IDLE:
  - On start=1: latch value into the operand registers and seed into lfsr. seed==0 is replaced by 1.
  - Set cnt=0 and go to RUN.
  - stop is ignored in IDLE.
- RUN, each cycle:
  - For each channel i: r_i = rotl(lfsr, i mod WIDTH) - 1, range 0..2^WIDTH-2.
  - out[i] <= (operand_i > r_i); out_valid <= 1.
  - Advance lfsr; cnt <= cnt+1.
  - When cnt==LEN-1, this is the last bit: go to DONE.
- LFSR: Fibonacci, shift left, new bit0 = XOR of the tap bits. Taps (1-based bit positions):
  - WIDTH=4: 4,3
  - WIDTH=8: 8,6,5,4
  - WIDTH=10: 10,7
  - Maximal-length; period 2^WIDTH-1; never reaches 0.
- DONE: out=0, out_valid=0, done=1 for exactly one cycle, then return to IDLE. start is ignored in DONE.
- busy: 1 in RUN and DONE.
- Latency: start accepted at edge t gives first out_valid at the register output after edge t+1. There are exactly LEN consecutive out_valid cycles, then one done cycle.
- Exactness: when LEN == 2^WIDTH-1, each channel emits exactly operand_i ones, clamped at 2^WIDTH-1. Each rotation is a bijection on nonzero states.
- stop in RUN:
  - Next state is IDLE; out and out_valid clear on the next edge.
  - No done pulse. lfsr holds its value; cnt clears.
  - stop and the last bit in the same cycle: stop wins, no done.
- Operand stability: value and seed changes during RUN have no effect until the next accepted start.
- Reset mid-stream: rst during RUN or DONE returns immediately to the reset values; no done pulse.

Optional Feature:
- Macro SNG_CONT_EN.
- Defined (continuous mode):
  - At cnt==LEN-1 the block stays in RUN and cnt wraps to 0.
  - value is re-latched into the operand registers at that same edge.
  - done pulses concurrently with the first bit of the next period; out_valid stays 1 continuously.
  - lfsr is not reseeded at the wrap.
  - Only stop or rst leaves RUN; DONE is never entered.
- Undefined (single-shot): behaviour exactly as in Behaviour.

Test Plan:
1. WIDTH=8, LEN=255, all channels value=128, seed=1, pulse start -> exactly 255 out_valid cycles; each channel's ones-count = 128; done high one cycle after, then busy=0.
2. Channel 0 value=0, channel 1 value=255, others 37, LEN=255 -> ones-counts 0, 255, 37 exactly; channel 0 out never 1.
3. seed=0 with value=200 all channels -> identical bitstream and counts to a run with seed=1.
4. stop asserted on the 10th valid cycle -> out_valid falls on the next edge after exactly 10 valid cycles, no done pulse, busy=0; a new start then produces a full 255-cycle run.
5. start held high for the whole run, and value changed mid-run -> no restart, counts reflect the originally latched operands; rst asserted mid-run -> all outputs 0 immediately, no done.
6. SNG_CONT_EN defined, LEN=255, value=64 then changed to 192 during the first period -> period 1 count = 64, period 2 count = 192; done pulses at cycles 256 and 511; out_valid never drops.
